// File: rtl/flop_r.sv
// flop_r: N-bit D register with synchronous, active-high reset.
// Reset loads RESET_VALUE and takes priority over d; otherwise q follows d
// with exactly one clock of latency. There is no enable: q is rewritten on
// every rising edge of clk.
//
// Optional simulation-only checking is compiled when FLOP_R_ASSERT_EN is
// defined. Without it the block is a plain register with identical ports.
module flop_r #(
   parameter int          N           = 64,
   parameter logic [N-1:0] RESET_VALUE = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   // Capture d each edge, or load the reset value when reset is sampled high.
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= RESET_VALUE;
      end else begin
         q <= d;
      end
   end

`ifdef FLOP_R_ASSERT_EN
   // The checks only make sense once a known reset has been applied; before
   // that q and the inputs are allowed to be X.
   logic checks_armed;

   // Arm the checks at the first edge where reset is seen asserted.
   always_ff @(posedge clk) begin
      if (reset === 1'b1) begin
         checks_armed <= 1'b1;
      end else if (checks_armed !== 1'b1) begin
         checks_armed <= 1'b0;
      end
   end

   property p_reset_loads;
      @(posedge clk) disable iff (checks_armed !== 1'b1)
         $past(reset) |-> (q == RESET_VALUE);
   endproperty

   property p_data_follows;
      @(posedge clk) disable iff (checks_armed !== 1'b1)
         !$past(reset) |-> (q == $past(d));
   endproperty

   property p_inputs_known;
      @(posedge clk) disable iff (checks_armed !== 1'b1)
         !$isunknown({reset, d});
   endproperty

   a_reset_loads:  assert property (p_reset_loads)
      else $error("flop_r: q does not hold RESET_VALUE after a reset edge");
   a_data_follows: assert property (p_data_follows)
      else $error("flop_r: q does not match d sampled at the previous edge");
   a_inputs_known: assert property (p_inputs_known)
      else $error("flop_r: reset or d is X/Z at a clock edge");
`endif

endmodule

// File: tb/tb_flop_r.sv
// Testbench for flop_r: a 64-bit instance with zero reset value and an
// 8-bit instance with RESET_VALUE 8'hA5, driven from table vectors,
// hand-written edge-timing sequences and randomized traffic checked
// against a simple "next q = reset ? RESET_VALUE : d" reference model.
module tb_flop_r;

   localparam logic [63:0] ONES64 = {64{1'b1}};
   localparam logic [7:0]  RV8    = 8'hA5;

   logic        clk;
   logic        reset;
   logic [63:0] d;
   logic [63:0] q;
   logic        reset8;
   logic [7:0]  d8;
   logic [7:0]  q8;

   int checks;
   int errors;

   typedef struct {
      logic        rst;
      logic [63:0] din;
      logic [63:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   flop_r #(.N(64)) dut64 (
      .clk   (clk),
      .reset (reset),
      .d     (d),
      .q     (q)
   );

   flop_r #(.N(8), .RESET_VALUE(RV8)) dut8 (
      .clk   (clk),
      .reset (reset8),
      .d     (d8),
      .q     (q8)
   );

   // 20 ns clock period
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // Safety net so the run always ends on its own.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive the 64-bit instance 1 ns after the next rising edge.
   task automatic applyStimulus(input logic r, input logic [63:0] dv);
      @(posedge clk);
      #1;
      reset = r;
      d     = dv;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      logic [63:0] exp64;
      logic [7:0]  exp8;
      logic        r;
      logic        r8;
      logic [63:0] dv;
      logic [7:0]  dv8;

      checks = 0;
      errors = 0;
      reset  = 1'b1;
      d      = '0;
      reset8 = 1'b1;
      d8     = 8'h00;

      // Reset held for several cycles while d changes: q stays at reset value.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         d  = 64'(i);
         d8 = 8'(i + 1);
         @(negedge clk);
         checkOutput($sformatf("reset_hold_%0d", i), q, 64'd0);
         checkOutput($sformatf("reset_hold8_%0d", i), {56'd0, q8}, {56'd0, RV8});
      end

      // Table-driven vectors: release, tracking, priority and reassertion.
      vecs.push_back('{1'b0, 64'd5, 64'd5, "release_d5"});
      for (int i = 0; i < 10; i++) begin
         vecs.push_back('{1'b0, 64'(i), 64'(i), $sformatf("track_%0d", i)});
      end
      vecs.push_back('{1'b1, ONES64, 64'd0, "priority_ones"});
      vecs.push_back('{1'b0, ONES64, ONES64, "release_ones"});
      vecs.push_back('{1'b0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, "msb_lsb"});
      vecs.push_back('{1'b1, 64'h1234, 64'd0, "reassert"});
      vecs.push_back('{1'b0, 64'hDEAD_BEEF_0BAD_F00D, 64'hDEAD_BEEF_0BAD_F00D, "pattern"});

      foreach (vecs[k]) begin
         applyStimulus(vecs[k].rst, vecs[k].din);
         @(posedge clk);
         @(negedge clk);
         checkOutput(vecs[k].name, q, vecs[k].exp);
      end

      // d toggled between edges must not leak into q.
      applyStimulus(1'b0, 64'd3);
      @(posedge clk);
      #4 d = 64'd7;
      #4 checkOutput("glitch_hold_a", q, 64'd3);
      #2 d = 64'd3;
      #2 checkOutput("glitch_hold_b", q, 64'd3);
      d = 64'd7;
      @(posedge clk);
      #1 checkOutput("glitch_capture", q, 64'd7);

      // Reset raised mid-cycle clears q only at the next edge.
      d = 64'd9;
      @(posedge clk);
      @(negedge clk);
      checkOutput("pre_midreset", q, 64'd9);
      reset = 1'b1;
      #3 checkOutput("midreset_hold", q, 64'd9);
      @(posedge clk);
      #1 checkOutput("midreset_clear", q, 64'd0);
      d = 64'h55;

      // Reset dropped mid-cycle does not change q until the next edge.
      @(negedge clk);
      reset = 1'b0;
      #3 checkOutput("midrelease_hold", q, 64'd0);
      @(posedge clk);
      #1 checkOutput("midrelease_capture", q, 64'h55);

      // 8-bit instance with non-zero reset value.
      reset8 = 1'b1;
      d8     = 8'hFF;
      @(posedge clk);
      #1 checkOutput("n8_reset", {56'd0, q8}, {56'd0, RV8});
      reset8 = 1'b0;
      d8     = 8'h3C;
      @(posedge clk);
      #1 checkOutput("n8_capture", {56'd0, q8}, 64'h3C);

      // Randomized traffic on both instances against the reference model.
      for (int i = 0; i < 300; i++) begin
         r   = ($urandom_range(0, 7) == 0);
         r8  = ($urandom_range(0, 5) == 0);
         dv  = {$urandom, $urandom};
         dv8 = 8'($urandom);
         exp64 = r  ? 64'd0 : dv;
         exp8  = r8 ? RV8   : dv8;
         applyStimulus(r, dv);
         reset8 = r8;
         d8     = dv8;
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("rand64_%0d", i), q, exp64);
         checkOutput($sformatf("rand8_%0d", i), {56'd0, q8}, {56'd0, exp8});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
